// File: rtl/seq_mult_ctrl.sv
// Iterative shift-add multiplier (signed/unsigned) with IDLE/RUN/FIN control and a Start/Done handshake.
// Optional build macro EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module seq_mult_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Signed_Mode,
  input  logic [WIDTH-1:0]     Data_A,
  input  logic [WIDTH-1:0]     Data_B,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Prod,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   a_reg;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     b_reg;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;

  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic                 last_iter;
  logic                 early_stop;

  // The most-negative operand negates to 2^(WIDTH-1), which is still correct read as unsigned.
  always_comb begin
    mag_a = (Signed_Mode && Data_A[WIDTH-1]) ? -Data_A : Data_A;
    mag_b = (Signed_Mode && Data_B[WIDTH-1]) ? -Data_B : Data_B;
  end

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef EARLY_TERM_EN
  assign early_stop = (b_reg == '0);
`else
  assign early_stop = 1'b0;
`endif

  assign dbg_state = state;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Prod  <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            a_reg <= {{WIDTH{1'b0}}, mag_a};
            b_reg <= mag_b;
            neg   <= Signed_Mode & (Data_A[WIDTH-1] ^ Data_B[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (early_stop) begin
            state <= FIN;
          end else begin
            if (b_reg[0]) acc <= acc + a_reg;
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            cnt   <= cnt + CNT_W'(1);
            if (last_iter) state <= FIN;
          end
        end
        FIN: begin
          Prod  <= neg ? -acc : acc;
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl: an 8-bit and a 32-bit instance checked against arithmetic reference products.
module tb_seq_mult_ctrl;

  logic        Clock = 1'b0;
  logic        Reset;
  always #5 Clock = ~Clock;

  logic        s8_start, s8_sm, s8_busy, s8_done;
  logic [7:0]  s8_a, s8_b;
  logic [15:0] s8_prod;
  logic [1:0]  s8_state;

  logic        s32_start, s32_sm, s32_busy, s32_done;
  logic [31:0] s32_a, s32_b;
  logic [63:0] s32_prod;
  logic [1:0]  s32_state;

  int total = 0;
  int bad   = 0;

  seq_mult_ctrl #(.WIDTH(8)) dut8 (
    .Clock(Clock), .Reset(Reset), .Start(s8_start), .Signed_Mode(s8_sm),
    .Data_A(s8_a), .Data_B(s8_b), .Busy(s8_busy), .Done(s8_done),
    .Prod(s8_prod), .dbg_state(s8_state)
  );

  seq_mult_ctrl #(.WIDTH(32)) dut32 (
    .Clock(Clock), .Reset(Reset), .Start(s32_start), .Signed_Mode(s32_sm),
    .Data_A(s32_a), .Data_B(s32_b), .Busy(s32_busy), .Done(s32_done),
    .Prod(s32_prod), .dbg_state(s32_state)
  );

  // Reference product: sign- or zero-extend to a wide signed value and multiply.
  function automatic logic [63:0] model_prod(input int w, input bit sm, input logic [31:0] a, input logic [31:0] b);
    logic signed [127:0] ea, eb, p;
    if (w == 8) begin
      ea = {{120{sm & a[7]}}, a[7:0]};
      eb = {{120{sm & b[7]}}, b[7:0]};
    end else begin
      ea = {{96{sm & a[31]}}, a};
      eb = {{96{sm & b[31]}}, b};
    end
    p = ea * eb;
    return (w == 8) ? (p[63:0] & 64'hFFFF) : p[63:0];
  endfunction

  // Edges from acceptance to the edge that raises Done.
  function automatic int model_lat(input int w, input bit sm, input logic [31:0] b);
    logic [31:0] mb;
    int h;
    if (w == 8) mb = (sm && b[7]) ? ((32'd256 - {24'b0, b[7:0]}) & 32'hFF) : {24'b0, b[7:0]};
    else        mb = (sm && b[31]) ? (32'd0 - b) : b;
    h = -1;
    for (int i = 0; i < 32; i++) if (mb[i]) h = i;
`ifdef EARLY_TERM_EN
    if (h + 3 < w + 1) return h + 3;
    return w + 1;
`else
    return (h >= 0) ? w + 1 : w + 1;
`endif
  endfunction

  task automatic drive(input bit w32, input bit st, input bit sm, input logic [31:0] a, input logic [31:0] b);
    if (w32) begin
      s32_start = st; s32_sm = sm; s32_a = a; s32_b = b;
    end else begin
      s8_start = st; s8_sm = sm; s8_a = a[7:0]; s8_b = b[7:0];
    end
  endtask

  function automatic logic busy_of(input bit w32);
    return w32 ? s32_busy : s8_busy;
  endfunction

  function automatic logic done_of(input bit w32);
    return w32 ? s32_done : s8_done;
  endfunction

  function automatic logic [63:0] prod_of(input bit w32);
    return w32 ? s32_prod : {48'b0, s8_prod};
  endfunction

  // One complete multiply: returns product, edge count to Done, and whether Busy behaved.
  task automatic run_mul(input bit w32, input bit sm, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] prod, output int lat, output bit busy_ok, output bit timed_out);
    @(negedge Clock);
    drive(w32, 1'b1, sm, a, b);
    @(posedge Clock); #1;
    busy_ok = (busy_of(w32) === 1'b1);
    @(negedge Clock);
    drive(w32, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
    lat = 0; timed_out = 1'b1; prod = '0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge Clock); #1;
      if (done_of(w32) === 1'b1) begin
        lat = c; timed_out = 1'b0; prod = prod_of(w32);
        if (busy_of(w32) !== 1'b0) busy_ok = 1'b0;
        break;
      end else if (busy_of(w32) !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock); Reset = 1'b0;
    @(posedge Clock); #1;
    total++; if (s8_busy !== 1'b0) begin bad++; $display("FAIL reset_busy8 got=%b want=0", s8_busy); end
    total++; if (s8_done !== 1'b0) begin bad++; $display("FAIL reset_done8 got=%b want=0", s8_done); end
    total++; if (s8_prod !== 16'h0) begin bad++; $display("FAIL reset_prod8 got=%h want=0", s8_prod); end
    total++; if (s8_state !== 2'd0) begin bad++; $display("FAIL reset_state8 got=%0d want=0", s8_state); end
    total++; if (s32_busy !== 1'b0) begin bad++; $display("FAIL reset_busy32 got=%b want=0", s32_busy); end
    total++; if (s32_done !== 1'b0) begin bad++; $display("FAIL reset_done32 got=%b want=0", s32_done); end
    total++; if (s32_prod !== 64'h0) begin bad++; $display("FAIL reset_prod32 got=%h want=0", s32_prod); end
  endtask

  task automatic test_directed();
    bit          t_w32[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bit          t_sm[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_a[6]   = '{32'd13, 32'h80, 32'hFD, 32'hFFFF_FFFF, 32'd5, 32'd5};
    logic [31:0] t_b[6]   = '{32'd11, 32'h80, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'd1};
    logic [63:0] t_p[6]   = '{64'd143, 64'h4000, 64'hFFEB, 64'hFFFF_FFFE_0000_0001, 64'd0, 64'd5};
    logic [63:0] p;
    int lat;
    bit bok, tmo;
    for (int i = 0; i < 6; i++) begin
      run_mul(t_w32[i], t_sm[i], t_a[i], t_b[i], p, lat, bok, tmo);
      total++; if (tmo) begin bad++; $display("FAIL dir%0d_timeout got=no_done want=done", i); end
      total++; if (p !== t_p[i]) begin bad++; $display("FAIL dir%0d_prod got=%h want=%h", i, p, t_p[i]); end
      total++; if (lat != model_lat(t_w32[i] ? 32 : 8, t_sm[i], t_b[i]))
        begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, model_lat(t_w32[i] ? 32 : 8, t_sm[i], t_b[i])); end
      total++; if (!bok) begin bad++; $display("FAIL dir%0d_busy got=bad want=high_until_done", i); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, p_exp;
    logic [63:0] p, exp_p;
    bit w32, sm, bok, tmo;
    int lat, w;
    for (int i = 0; i < 40; i++) begin
      w32 = i[0]; w = w32 ? 32 : 8;
      sm = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: a = w32 ? 32'h8000_0000 : 32'h80;
        2: b = w32 ? 32'hFFFF_FFFF : 32'hFF;
        3: b = 32'($urandom_range(0, 15));
        default: ;
      endcase
      p_exp = 32'd0;
      exp_p = model_prod(w, sm, a, b);
      run_mul(w32, sm, a, b, p, lat, bok, tmo);
      total++; if (tmo || p !== exp_p)
        begin bad++; $display("FAIL rand%0d_prod w=%0d sm=%0d a=%h b=%h got=%h want=%h", i, w, sm, a, b, p, exp_p); end
      total++; if (lat != model_lat(w, sm, b))
        begin bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", i, lat, model_lat(w, sm, b)); end
      total++; if (!bok) begin bad++; $display("FAIL rand%0d_busy got=bad want=high_until_done", i); end
      if (p_exp != 32'd0) $display("unreachable");
    end
  endtask

  task automatic test_start_during_run();
    int dones = 0, first_c = 0;
    logic [15:0] first_p = '0;
    @(negedge Clock); drive(1'b0, 1'b1, 1'b0, 32'd200, 32'h83);
    @(posedge Clock);
    for (int c = 1; c <= 25; c++) begin
      @(negedge Clock);
      if (c == 3) drive(1'b0, 1'b1, 1'b1, 32'h07, 32'h09);
      else        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(posedge Clock); #1;
      if (s8_done === 1'b1) begin
        dones++;
        if (dones == 1) begin first_c = c; first_p = s8_prod; end
      end
    end
    total++; if (dones != 1) begin bad++; $display("FAIL ignore_start_dones got=%0d want=1", dones); end
    total++; if (first_p !== 16'd26200) begin bad++; $display("FAIL ignore_start_prod got=%0d want=26200", first_p); end
    total++; if (first_c != model_lat(8, 1'b0, 32'h83))
      begin bad++; $display("FAIL ignore_start_latency got=%0d want=%0d", first_c, model_lat(8, 1'b0, 32'h83)); end
  endtask

  task automatic test_reset_mid();
    int dones = 0, lat;
    logic [63:0] p;
    bit bok, tmo;
    @(negedge Clock); drive(1'b0, 1'b1, 1'b1, 32'h9C, 32'hB7);
    @(posedge Clock);
    @(negedge Clock); drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge Clock);
    @(negedge Clock); Reset = 1'b1;
    @(posedge Clock); #1;
    total++; if (s8_busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", s8_busy); end
    total++; if (s8_prod !== 16'h0) begin bad++; $display("FAIL midreset_prod got=%h want=0", s8_prod); end
    total++; if (s8_done !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b want=0", s8_done); end
    @(negedge Clock); Reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge Clock); #1;
      if (s8_done === 1'b1) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL midreset_no_done got=%0d want=0", dones); end
    run_mul(1'b0, 1'b1, 32'hFD, 32'h7F, p, lat, bok, tmo);
    total++; if (tmo || p !== model_prod(8, 1'b1, 32'hFD, 32'h7F))
      begin bad++; $display("FAIL midreset_after_prod got=%h want=%h", p, model_prod(8, 1'b1, 32'hFD, 32'h7F)); end
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    int got_q[$];
    logic [63:0] exp_p;
    int l, g, e, bad_prod = 0;
    l = model_lat(8, 1'b0, 32'd29);
    exp_q.push_back(l); exp_q.push_back(2 * l + 1); exp_q.push_back(3 * l + 2);
    exp_p = model_prod(8, 1'b0, 32'd17, 32'd29);
    @(negedge Clock); drive(1'b0, 1'b1, 1'b0, 32'd17, 32'd29);
    @(posedge Clock);
    for (int c = 1; c <= 3 * l + 2; c++) begin
      @(posedge Clock); #1;
      if (s8_done === 1'b1) begin
        got_q.push_back(c);
        if ({48'b0, s8_prod} !== exp_p) bad_prod++;
      end
    end
    @(negedge Clock); drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL b2b_done_count got=%0d want=3", got_q.size()); end
    total++; if (bad_prod != 0) begin bad++; $display("FAIL b2b_prod got=%0d_wrong want=0_wrong", bad_prod); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g != e) begin bad++; $display("FAIL b2b_done_edge got=%0d want=%0d", g, e); end
    end
    for (int c = 0; c < 20 && s8_busy === 1'b1; c++) @(posedge Clock);
    repeat (2) @(posedge Clock);
  endtask

  task automatic test_hold();
    int dones = 0;
    logic [63:0] exp_p;
    exp_p = model_prod(8, 1'b0, 32'd17, 32'd29);
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock); drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      @(posedge Clock); #1;
      if (s8_done === 1'b1) dones++;
    end
    total++; if ({48'b0, s8_prod} !== exp_p) begin bad++; $display("FAIL hold_prod got=%h want=%h", s8_prod, exp_p); end
    total++; if (dones != 0) begin bad++; $display("FAIL hold_no_done got=%0d want=0", dones); end
  endtask

  initial begin
    Reset = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_start_during_run();
    test_reset_mid();
    test_back_to_back();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
Parametrised iterative shift-add multiplier with an integrated control FSM and a start/done handshake.
- Generalises the fixed 32-bit multiplier datapath to any operand width.
- Adds signed/unsigned operation, busy/done signalling and result hold.
- Sits between a register-file/ALU front end and a writeback stage; one multiplication in flight at a time.

Parameters:
WIDTH, 32, operand width in bits (>=2); product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+1), width of the internal iteration counter.

Ports:
Clock  input  1  system clock, all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  request pulse/level; sampled only in IDLE.
Signed_Mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with Start.
Data_A  input  WIDTH  multiplicand, sampled with Start.
Data_B  input  WIDTH  multiplier, sampled with Start.
Busy  output  1  high from the edge after Start acceptance until Done.
Done  output  1  one-cycle pulse, product valid.
Prod  output  2*WIDTH  registered product; holds until next Done or Reset.

Behaviour:
- Reset: synchronous, active-high; Reset is Reset, clock is Clock. On reset: state=IDLE, Busy=0, Done=0, Prod=0, internal A/B/accumulator/counter=0. Reset mid-operation aborts; no Done is produced.
- States: IDLE, RUN, FIN.
- IDLE: Start=1 at edge k -> load registers and go to RUN.
  - Signed_Mode=1: load |Data_A| zero-extended to 2*WIDTH into A_reg, |Data_B| into B_reg; latch neg = sign(A) XOR sign(B). Magnitude of the most-negative value (2^(WIDTH-1)) fits unsigned in WIDTH bits.
  - Signed_Mode=0: load operands directly; neg=0.
  - Accumulator and counter cleared; Busy=1 from edge k.
- RUN: one iteration per edge.
  - If B_reg[0]=1: acc <= acc + A_reg (2*WIDTH wide, no overflow possible).
  - Then A_reg <= A_reg<<1, B_reg <= B_reg>>1, cnt++.
  - When cnt reaches WIDTH-1 at an iteration edge, next state is FIN. Exactly WIDTH iterations occur, on edges k+1..k+WIDTH.
- FIN: at edge k+WIDTH+1:
  - Prod <= neg ? -acc : acc (two's complement, 2*WIDTH bits).
  - Done=1 for that one cycle; Busy=0; return to IDLE.
- Latency: Start accepted at edge k -> Done/Prod valid after edge k+WIDTH+1.
- Start while Busy=1 or during the FIN cycle: ignored, no queuing. Start held high continuously is re-accepted at the first IDLE edge after Done.
- Start and Reset together: Reset wins.
- Data_A, Data_B and Signed_Mode may change freely after acceptance without affecting the result.
- Prod is stable between Done pulses. Acc is internal and never exposed mid-operation.

Optional Feature:
Macro EARLY_TERM_EN.
- Defined: in RUN, if B_reg==0 at an edge, that edge performs no iteration and moves to FIN. Done therefore arrives at k+2+(index of highest set bit of |B|+1), minimum edge k+2 when |B|=0. Result is identical.
- Undefined: fixed WIDTH iterations; latency always WIDTH+1.

Test Plan:
- WIDTH=8, unsigned, A=13, B=11, Start at edge k -> Done pulse after edge k+9, Prod=143, Busy high edges k..k+8.
- WIDTH=8, signed, A=-128 (0x80), B=-128 -> Prod=16384 (0x4000); A=-3, B=7 -> Prod=0xFFEB (-21).
- WIDTH=32, unsigned, A=B=0xFFFFFFFF -> Prod=0xFFFFFFFE00000001 after 33 cycles.
- Start re-pulsed during RUN with different operands -> ignored, first result delivered unchanged, single Done.
- Reset asserted at iteration 4 of an 8-bit multiply -> next cycle Busy=0, Prod=0, no Done; new Start afterward computes correctly.
- EARLY_TERM_EN defined, WIDTH=32, B=0 -> Done after edge k+2, Prod=0; B=1, A=5 -> Done after edge k+3, Prod=5.
